// File: rtl/soc_timebase_csr.sv
// Bus-addressable microsecond timebase: prescaler, 32-bit usec counter, compare/IRQ,
// and a two-state responder on the SOC data bus.
module soc_timebase_csr #(
    parameter int unsigned NUM_1US_CLKS  = 64,
    parameter int unsigned CNT_1US_WIDTH = 6
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        bus_vld,
    input  logic [31:2] bus_addr,
    input  logic [3:0]  bus_we,
    input  logic [31:0] bus_wdat,
    output logic        bus_rdy,
    output logic [31:0] bus_rdat,
    output logic        tick_1us,
    output logic [31:0] usec,
    output logic        irq
);

    // The prescaler must hold NUM_1US_CLKS itself, which can need one bit more than
    // CNT_1US_WIDTH when the terminal count is a power of two.
    localparam int unsigned MinW = $clog2(NUM_1US_CLKS + 1);
    localparam int unsigned PreW = (CNT_1US_WIDTH > MinW) ? CNT_1US_WIDTH : MinW;
    localparam logic [PreW-1:0] PreMax = PreW'(NUM_1US_CLKS);

    typedef enum logic [0:0] {StIdle, StResp} state_e;

    state_e            state_q, state_d;
    logic [31:0]       rdat_q, rdat_d;
    logic [PreW-1:0]   pre_q, pre_d;
    logic [31:0]       usec_q, usec_d;
    logic [31:0]       cmp_q, cmp_d;
    logic              en_q, en_d;
    logic              irq_en_q, irq_en_d;
    logic              hit_q, hit_d;

    logic              accept, wr, tick, clr, hit_set;
    logic [1:0]        reg_sel;
    logic [31:0]       rd_mux;
    logic              unused_addr;

    assign unused_addr = ^bus_addr[31:4];
    assign reg_sel     = bus_addr[3:2];
    assign accept      = (state_q == StIdle) && bus_vld;
    assign wr          = accept && (bus_we != 4'b0000);
    assign tick        = en_q && (pre_q == PreMax);
    assign clr         = wr && (reg_sel == 2'd0) && bus_we[0] && bus_wdat[2];
    // Compare against the pre-edge CMP so a coincident CMP write cannot affect this tick.
    assign hit_set     = tick && ((usec_q + 32'd1) == cmp_q);

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_val[8*i +: 8];
        end
        return r;
    endfunction

    always_comb begin
        rd_mux = 32'd0;
        case (reg_sel)
            2'd0:    rd_mux = {30'd0, irq_en_q, en_q};
            2'd1:    rd_mux = usec_q;
            2'd2:    rd_mux = cmp_q;
            default: rd_mux = {31'd0, hit_q};
        endcase
    end

    always_comb begin
        state_d = state_q;
        rdat_d  = 32'd0;
        unique case (state_q)
            StIdle: begin
                if (bus_vld) begin
                    state_d = StResp;
                    rdat_d  = rd_mux;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Priority, lowest first: count, bus write, CLR, then a new hit over its W1C.
    always_comb begin
        pre_d    = pre_q;
        usec_d   = usec_q;
        cmp_d    = cmp_q;
        en_d     = en_q;
        irq_en_d = irq_en_q;
        hit_d    = hit_q;
        if (en_q) pre_d = tick ? '0 : pre_q + 1'b1;
        if (tick) usec_d = usec_q + 32'd1;
        if (wr) begin
            case (reg_sel)
                2'd0: begin
                    if (bus_we[0]) begin
                        en_d     = bus_wdat[0];
                        irq_en_d = bus_wdat[1];
                    end
                end
                2'd1:    usec_d = merge_bytes(usec_q, bus_wdat, bus_we);
                2'd2:    cmp_d  = merge_bytes(cmp_q, bus_wdat, bus_we);
                default: if (bus_we[0] && bus_wdat[0]) hit_d = 1'b0;
            endcase
        end
        if (clr) begin
            pre_d  = '0;
            usec_d = 32'd0;
        end
        if (hit_set) hit_d = 1'b1;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= StIdle;
            rdat_q   <= 32'd0;
            pre_q    <= '0;
            usec_q   <= 32'd0;
            cmp_q    <= 32'hFFFF_FFFF;
            en_q     <= 1'b1;
            irq_en_q <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdat_q   <= rdat_d;
            pre_q    <= pre_d;
            usec_q   <= usec_d;
            cmp_q    <= cmp_d;
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            hit_q    <= hit_d;
        end
    end

    assign bus_rdy  = (state_q == StResp);
    assign bus_rdat = rdat_q;
    assign tick_1us = tick;
    assign usec     = usec_q;
    assign irq      = hit_q & irq_en_q;

endmodule

// File: tb/tb_soc_timebase_csr.sv
// Scoreboard bench for soc_timebase_csr: a cycle-level reference model predicts every
// output; a negedge monitor compares registered outputs and pops expected read data.
module tb_soc_timebase_csr;

    localparam int N = 64;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        bus_vld = 1'b0;
    logic [31:2] bus_addr = '0;
    logic [3:0]  bus_we = 4'd0;
    logic [31:0] bus_wdat = 32'd0;
    logic        bus_rdy;
    logic [31:0] bus_rdat;
    logic        tick_1us;
    logic [31:0] usec;
    logic        irq;

    soc_timebase_csr dut (
        .clk      (clk),
        .arst_n   (arst_n),
        .bus_vld  (bus_vld),
        .bus_addr (bus_addr),
        .bus_we   (bus_we),
        .bus_wdat (bus_wdat),
        .bus_rdy  (bus_rdy),
        .bus_rdat (bus_rdat),
        .tick_1us (tick_1us),
        .usec     (usec),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rdat = 32'd0;

    // Reference model state
    logic [31:0] m_usec, m_cmp;
    int          m_pre;
    logic        m_en, m_irqen, m_hit;
    logic        m_resp = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: required event did not occur within bound at %0t", name, $time);
    endtask

    task automatic model_reset();
        m_usec  = 32'd0;
        m_cmp   = 32'hFFFF_FFFF;
        m_pre   = 0;
        m_en    = 1'b1;
        m_irqen = 1'b0;
        m_hit   = 1'b0;
        m_resp  = 1'b0;
    endtask

    function automatic logic [31:0] mread(input logic [1:0] a);
        case (a)
            2'd0:    return {30'd0, m_irqen, m_en};
            2'd1:    return m_usec;
            2'd2:    return m_cmp;
            default: return {31'd0, m_hit};
        endcase
    endfunction

    function automatic logic [31:0] bytes_upd(input logic [31:0] o, input logic [31:0] n,
                                              input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // Advance the model by one clock edge using the pre-edge inputs and state.
    task automatic model_edge();
        logic acc, wr, tk, clr, hs, w1c;
        logic [1:0] a;
        logic [31:0] nu;
        if (!arst_n) return;
        a   = bus_addr[3:2];
        acc = bus_vld && !m_resp;
        wr  = acc && (bus_we != 4'd0);
        tk  = m_en && (m_pre == N);
        clr = wr && a == 2'd0 && bus_we[0] && bus_wdat[2];
        w1c = wr && a == 2'd3 && bus_we[0] && bus_wdat[0];
        hs  = tk && ((m_usec + 32'd1) == m_cmp);
        nu  = tk ? m_usec + 32'd1 : m_usec;
        if (wr && a == 2'd1) nu = bytes_upd(m_usec, bus_wdat, bus_we);
        if (clr) nu = 32'd0;
        if (clr || tk) m_pre = 0;
        else if (m_en) m_pre = m_pre + 1;
        m_usec = nu;
        if (wr && a == 2'd2) m_cmp = bytes_upd(m_cmp, bus_wdat, bus_we);
        if (wr && a == 2'd0 && bus_we[0]) begin
            m_en    = bus_wdat[0];
            m_irqen = bus_wdat[1];
        end
        if (w1c) m_hit = 1'b0;
        if (hs) m_hit = 1'b1;
        m_resp = acc;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic issue(input logic [1:0] a, input logic [3:0] we, input logic [31:0] d);
        bus_vld  = 1'b1;
        bus_addr = {28'($urandom), a};
        bus_we   = we;
        bus_wdat = d;
        exp_q.push_back(mread(a));
    endtask

    // Request held through the response cycle; the DUT must ignore it there.
    task automatic xfer(input logic [1:0] a, input logic [3:0] we, input logic [31:0] d);
        issue(a, we, d);
        cyc();
        cyc();
        bus_vld = 1'b0;
        bus_we  = 4'd0;
    endtask

    task automatic wait_pre(input int v);
        int n = 0;
        while (m_pre != v && n < 300) begin
            cyc();
            n++;
        end
        if (m_pre != v) fail_now("wait_prescaler");
    endtask

    task automatic wait_usec(input logic [31:0] v);
        int n = 0;
        while (m_usec != v && n < 300) begin
            cyc();
            n++;
        end
        if (m_usec != v) fail_now("wait_usec");
    endtask

    always @(negedge clk) begin
        chk("bus_rdy", 32'(bus_rdy), 32'(m_resp));
        if (bus_rdy) begin
            last_rdat = bus_rdat;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rdat_unexpected: got %h with no outstanding request", bus_rdat);
            end else begin
                chk("bus_rdat", bus_rdat, exp_q.pop_front());
            end
        end else begin
            chk("rdat_idle", bus_rdat, 32'd0);
        end
        chk("usec", usec, m_usec);
        chk("irq", 32'(irq), 32'(m_hit && m_irqen));
        chk("tick_1us", 32'(tick_1us), 32'(m_en && (m_pre == N)));
    end

    initial begin
        logic [31:0] u;
        int found;
        arst_n = 1'b1;
        model_reset();
        #1 arst_n = 1'b0;
        cyc();
        cyc();
        chk("rst_rdy", 32'(bus_rdy), 32'd0);
        chk("rst_rdat", bus_rdat, 32'd0);
        chk("rst_tick", 32'(tick_1us), 32'd0);
        chk("rst_usec", usec, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        arst_n = 1'b1;

        // Tick timing after reset release: cycle k is the k-th clock after release.
        for (int k = 0; k <= 195; k++) begin
            int ne;
            if (k > 0) cyc();
            ne = 0;
            if (k > 64) ne++;
            if (k > 129) ne++;
            if (k > 194) ne++;
            chk("tick_cycle", 32'(tick_1us), 32'(k == 64 || k == 129 || k == 194));
            chk("usec_count", usec, 32'(ne));
        end

        // Byte enables on CMP
        xfer(2'd2, 4'b1111, 32'h1122_3344);
        xfer(2'd2, 4'b0010, 32'hAABB_CCDD);
        xfer(2'd2, 4'b0000, 32'd0);
        chk("cmp_byte_en", last_rdat, 32'h1122_CC44);

        // Compare / IRQ
        xfer(2'd1, 4'hF, 32'h10);
        xfer(2'd2, 4'hF, 32'h12);
        xfer(2'd0, 4'hF, 32'h3);
        for (int n = 0; n < 300 && m_usec != 32'h12; n++) begin
            chk("irq_early", 32'(irq), 32'd0);
            cyc();
        end
        if (m_usec != 32'h12) fail_now("wait_hit");
        chk("irq_on_hit", 32'(irq), 32'd1);
        xfer(2'd3, 4'd0, 32'd0);
        chk("hit_read", last_rdat, 32'd1);
        xfer(2'd3, 4'b0001, 32'd1);
        chk("irq_w1c", 32'(irq), 32'd0);
        xfer(2'd1, 4'hF, 32'h12);
        chk("usec_wr_no_hit", 32'(irq), 32'd0);

        // Wrap-around hit
        wait_pre(0);
        xfer(2'd1, 4'hF, 32'hFFFF_FFFF);
        xfer(2'd2, 4'hF, 32'd0);
        wait_usec(32'd0);
        chk("wrap_usec", usec, 32'd0);
        chk("wrap_hit", 32'(irq), 32'd1);

        // W1C coinciding with a new hit: set wins
        wait_pre(0);
        xfer(2'd3, 4'b0001, 32'd1);
        xfer(2'd2, 4'hF, m_usec + 32'd1);
        chk("hit_cleared", 32'(irq), 32'd0);
        wait_pre(N);
        xfer(2'd3, 4'b0001, 32'd1);
        chk("w1c_vs_hit", 32'(irq), 32'd1);

        // USEC write in the tick cycle: write wins
        wait_pre(N);
        xfer(2'd1, 4'hF, 32'h55);
        chk("usec_wr_vs_tick", usec, 32'h55);

        // EN=0 freezes everything
        xfer(2'd0, 4'hF, 32'h2);
        u = usec;
        for (int n = 0; n < 200; n++) begin
            cyc();
            chk("en0_tick", 32'(tick_1us), 32'd0);
            chk("en0_usec", usec, u);
        end
        xfer(2'd0, 4'hF, 32'h3);
        wait_pre(30);
        issue(2'd0, 4'b0001, 32'h7);
        cyc();
        chk("clr_usec", usec, 32'd0);
        found = -1;
        for (int k = 0; k < 200; k++) begin
            if (k == 1) begin
                bus_vld = 1'b0;
                bus_we  = 4'd0;
            end
            if (tick_1us) begin
                found = k;
                break;
            end
            cyc();
        end
        chk("clr_to_tick", 32'(found), 32'd64);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic [1:0] a;
            logic [3:0] we;
            logic [31:0] d;
            int gap;
            a  = 2'($urandom_range(0, 3));
            we = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
            d  = $urandom;
            if (a == 2'd0) begin
                d[0] = ($urandom_range(0, 7) != 0);
                d[2] = ($urandom_range(0, 7) == 0);
            end
            if (a == 2'd2 && $urandom_range(0, 1) == 1) d = m_usec + 32'($urandom_range(1, 3));
            xfer(a, we, d);
            gap = $urandom_range(0, 3);
            if ($urandom_range(0, 15) == 0) gap = 70;
            repeat (gap) cyc();
        end

        // Async reset in RESP with HIT=1
        xfer(2'd0, 4'hF, 32'h3);
        wait_pre(0);
        xfer(2'd1, 4'hF, 32'd5);
        xfer(2'd2, 4'hF, 32'd6);
        wait_usec(32'd6);
        chk("pre_rst_irq", 32'(irq), 32'd1);
        issue(2'd1, 4'd0, 32'd0);
        cyc();
        chk("pre_rst_rdy", 32'(bus_rdy), 32'd1);
        #1;
        arst_n  = 1'b0;
        bus_vld = 1'b0;
        model_reset();
        exp_q.delete();
        #1;
        chk("arst_rdy", 32'(bus_rdy), 32'd0);
        chk("arst_rdat", bus_rdat, 32'd0);
        chk("arst_irq", 32'(irq), 32'd0);
        chk("arst_usec", usec, 32'd0);
        chk("arst_tick", 32'(tick_1us), 32'd0);
        cyc();
        cyc();
        arst_n = 1'b1;
        repeat (70) cyc();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
